instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and program writer: accepts decoded instruction descriptions (class, register indices, funct fields, immediate) over a valid/ready handshake. Packs each one into a 32-bit RV32I word using the same opcode set that the control unit decodes. Streams the words into instruction memory at consecutive word addresses. Used by the boot/test loader to build programs in-system, so the encoder is the inverse of the opcode decoder.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width.
- `DEPTH`, default 1024: number of words that may be written after `start`; must be ≤ 2^ADDR_W.
- `clk` in, 1: single clock, rising edge.
- `reset` in, 1: asynchronous, active-high.
- `start` in, 1: pulse; loads the base address and clears the write count.
- `base_addr` in, ADDR_W: first word address, sampled on `start`.
- `req_valid` in, 1 / `req_ready` out, 1: request handshake.
- `req_class` in, 4: 0 RType, 1 IType, 2 LOAD, 3 STORE, 4 SBType, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR; 9–15 are illegal.
- `rd`, `rs1`, `rs2` in, 5 each: register indices.
- `funct3` in, 3; `funct7` in, 7: function fields.
- `imm` in, 32: immediate value, as a byte offset for B and J.
- `wr_valid` out, 1 / `wr_ready` in, 1: memory-write handshake.
- `wr_addr` out, ADDR_W: word address.
- `wr_data` out, 32: encoded instruction.
- `count` out, ADDR_W+1: number of words written since `start`.
- `full` out, 1: `count == DEPTH`.
- `err` out, 1: one-cycle pulse when a request is rejected.

## Operation
- **Encoding by class (opcode in bits [6:0]):**
  - R: funct7 | rs2 | rs1 | funct3 | rd, opcode 0110011.
  - I: imm[11:0] | rs1 | funct3 | rd, opcode 0010011. When funct3 is 001 or 101, bits [31:25] = funct7 and bits [24:20] = imm[4:0].
  - LOAD: I-format, opcode 0000011.
  - STORE: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0], opcode 0100011.
  - SBType: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11], opcode 1100011.
  - LUI: imm[31:12] | rd, opcode 0110111.
  - AUIPC: imm[31:12] | rd, opcode 0010111.
  - JAL: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd, opcode 1101111.
  - JALR: I-format with funct3 forced to 000, opcode 1100111.
- **Ignored inputs:** fields a format does not use are ignored. imm[0] is ignored for SBType and JAL.
- **Illegal class:** the request is accepted (handshake completes), nothing is written, and `err` pulses the next cycle.
- **Write FSM states:**
  - IDLE: after reset; `req_ready` = 0.
  - RUN: entered on `start`.
  - FULL: entered when `count` reaches DEPTH; `req_ready` = 0.
  - A new `start` from any state returns to RUN with `count` = 0 and the write pointer = `base_addr`.
- **Output stage:** one output register (valid + addr + data).
  - In RUN, `req_ready = !full_pending && (!wr_valid || wr_ready)`, where `full_pending` means count plus in-flight equals DEPTH.
  - An accepted legal request loads the output register; the pointer increments after the `wr_valid && wr_ready` transfer.
- **Arithmetic:** the pointer wraps modulo 2^ADDR_W. `count` saturates at DEPTH.
- **Priority:** `start` coincident with `req_valid` means `start` wins and the request is not accepted (`req_ready` is 0 in that cycle). `start` while `wr_valid` = 1 drops the pending word.

## Timing
- **Reset values:** `req_ready` 0, `wr_valid` 0, `wr_addr` 0, `wr_data` 0, `count` 0, `full` 0, `err` 0; state IDLE.
- **Latency:** request accepted at edge N gives `wr_valid` = 1 from N+1 through the transfer edge.
- **Throughput:** one word per cycle when `wr_ready` = 1.
- **Output stability:** `wr_addr` and `wr_data` stay stable while `wr_valid && !wr_ready`.
- **Status updates:** `full` asserts the cycle after the DEPTH-th transfer. `err` pulses for exactly one cycle.
- **Reset mid-write:** asynchronous reset clears everything immediately; the pending word is lost.

## Structure
- **Shared package `riscv_pkg`:** opcode constants (the 7-bit encodings), the `req_class` enum, and the DEPTH default.
- **Sub-module `instr_pack`:** combinational class+fields → 32-bit word plus an illegal flag.
- **Top level:** the FSM, counters, and output register.

## Test plan
- **Basic encodes:** `start` with base 0, then four requests with `wr_ready` = 1. Required words, in order:
  - IType rd1 rs1=0 funct3 0 imm 5 → 0x00500093 @0.
  - RType rd3 rs1=1 rs2=2 funct3 0 funct7 0 → 0x002081B3 @1.
  - STORE rs1=1 rs2=2 funct3 010 imm 8 → 0x0020A423 @2.
  - JAL rd1 imm 8 → 0x008000EF @3.
- **LUI and backpressure:** LUI rd5 imm 0x12345000 with `wr_ready` low for 3 cycles. Required: 0x123452B7 held stable, `req_ready` = 0 until the transfer, pointer advances by exactly 1.
- **Illegal class:** class 12 → `err` high for 1 cycle, no `wr_valid`, `count` unchanged.
- **Full and wrap:** DEPTH = 4, ADDR_W = 2, base 3. Required: addresses 3, 0, 1, 2; `full` = 1 after the 4th transfer; `req_ready` = 0 afterwards.
- **Reset and restart:** assert `reset` while `wr_valid` = 1, which clears all outputs asynchronously. Then `start` base 5 → next word is written @5 and `count` = 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, request classes and
// encoder write-FSM states.
package riscv_pkg;

  localparam int DEPTH_DEFAULT = 1024;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    CLS_R     = 4'd0,
    CLS_I     = 4'd1,
    CLS_LOAD  = 4'd2,
    CLS_STORE = 4'd3,
    CLS_SB    = 4'd4,
    CLS_LUI   = 4'd5,
    CLS_AUIPC = 4'd6,
    CLS_JAL   = 4'd7,
    CLS_JALR  = 4'd8
  } req_class_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction class and fields to a
// 32-bit RV32I word, flagging classes the decoder does not know.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic shamt;

  assign shamt = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (cls)
      CLS_R:
        word = {funct7, rs2, rs1, funct3, rd, OP_R};
      CLS_I:
        // shifts carry funct7 in the upper immediate bits
        if (shamt)
          word = {funct7, imm[4:0], rs1, funct3, rd, OP_I};
        else
          word = {imm[11:0], rs1, funct3, rd, OP_I};
      CLS_LOAD:
        word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      CLS_STORE:
        word = {imm[11:5], rs2, rs1, funct3,
                imm[4:0], OP_STORE};
      CLS_SB:
        word = {imm[12], imm[10:5], rs2, rs1, funct3,
                imm[4:1], imm[11], OP_BRANCH};
      CLS_LUI:
        word = {imm[31:12], rd, OP_LUI};
      CLS_AUIPC:
        word = {imm[31:12], rd, OP_AUIPC};
      CLS_JAL:
        word = {imm[20], imm[10:1], imm[11],
                imm[19:12], rd, OP_JAL};
      CLS_JALR:
        word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program writer: packs requests into RV32I words and streams
// them to instruction memory at consecutive word addresses.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_class,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic              illegal;
  logic              xfer;
  logic              accept;
  logic              load;
  logic              full_pending;

  instr_pack u_pack (
    .cls     (req_class),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .funct3  (funct3),
    .funct7  (funct7),
    .imm     (imm),
    .word    (word),
    .illegal (illegal)
  );

  assign xfer = wr_valid && wr_ready;

  // words already counted plus the one waiting in the register
  assign full_pending =
    (count + {{ADDR_W{1'b0}}, wr_valid}) == DEPTH_C;

  assign req_ready = (state == ST_RUN) && !start &&
                     !full_pending && (!wr_valid || wr_ready);

  assign accept = req_valid && req_ready;
  assign load   = accept && !illegal;
  assign full   = (count == DEPTH_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      count    <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
    end else if (start) begin
      state    <= ST_RUN;
      ptr      <= base_addr;
      count    <= '0;
      wr_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= accept && illegal;
      if (xfer) begin
        ptr <= ptr + PTR_ONE;
        if (count != DEPTH_C)
          count <= count + CNT_ONE;
        if (count + CNT_ONE == DEPTH_C)
          state <= ST_FULL;
      end
      if (load) begin
        wr_valid <= 1'b1;
        wr_addr  <= xfer ? ptr + PTR_ONE : ptr;
        wr_data  <= word;
      end else if (xfer) begin
        wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed program cases
// plus randomized batches against a field-arithmetic model.
module tb_instr_encoder;

  localparam int AW = 3;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_class = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [31:0]   imm = '0;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  logic rnd = 1'b0;
  logic rnd_bit = 1'b0;
  logic dir_ready = 1'b1;

  assign wr_ready = rnd ? rnd_bit : dir_ready;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;
  int xfer_at_start = 0;
  int unsigned m_next = 0;

  instr_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_class (req_class),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .count     (count),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rnd) begin
      #1;
      rnd_bit = ($urandom % 2) == 1;
    end
  end

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h",
               name, act, req);
    end
  endtask

  // monitor: a transfer happens at the next rising edge
  always @(negedge clk) begin
    if (!reset && wr_valid && wr_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: actual @%0d %h required none",
                 wr_addr, wr_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", wr_data, e.d);
      end
      n_xfer++;
    end
  end

  function automatic logic [31:0] ref_enc(
    int unsigned c, int unsigned rdv, int unsigned s1,
    int unsigned s2, int unsigned f3, int unsigned f7,
    logic [31:0] im);
    int unsigned u;
    int unsigned r;
    u = im;
    case (c)
      0: r = f7 << 25 | s2 << 20 | s1 << 15 | f3 << 12
             | rdv << 7 | 'h33;
      1: if (f3 == 1 || f3 == 5)
           r = f7 << 25 | (u % 32) << 20 | s1 << 15
               | f3 << 12 | rdv << 7 | 'h13;
         else
           r = (u % 4096) << 20 | s1 << 15 | f3 << 12
               | rdv << 7 | 'h13;
      2: r = (u % 4096) << 20 | s1 << 15 | f3 << 12
             | rdv << 7 | 'h03;
      3: r = ((u >> 5) % 128) << 25 | s2 << 20 | s1 << 15
             | f3 << 12 | (u % 32) << 7 | 'h23;
      4: r = ((u >> 12) % 2) << 31 | ((u >> 5) % 64) << 25
             | s2 << 20 | s1 << 15 | f3 << 12
             | ((u >> 1) % 16) << 8 | ((u >> 11) % 2) << 7
             | 'h63;
      5: r = (u / 4096) << 12 | rdv << 7 | 'h37;
      6: r = (u / 4096) << 12 | rdv << 7 | 'h17;
      7: r = ((u >> 20) % 2) << 31 | ((u >> 1) % 1024) << 21
             | ((u >> 11) % 2) << 20 | ((u >> 12) % 256) << 12
             | rdv << 7 | 'h6F;
      8: r = (u % 4096) << 20 | s1 << 15 | rdv << 7 | 'h67;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic set_ready(logic r, logic v);
    @(posedge clk);
    #1;
    rnd = r;
    dir_ready = v;
  endtask

  task automatic do_start(int unsigned b);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b[AW-1:0];
    m_next = b;
    @(posedge clk);
    xfer_at_start = n_xfer;
    #1;
    start = 1'b0;
  endtask

  task automatic do_req(int unsigned c, int unsigned rdv,
                        int unsigned s1, int unsigned s2,
                        int unsigned f3, int unsigned f7,
                        logic [31:0] im, logic [31:0] w);
    bit ok;
    bit legal;
    legal = (c <= 8);
    @(posedge clk);
    #1;
    req_class = c[3:0];
    rd = rdv[4:0];
    rs1 = s1[4:0];
    rs2 = s2[4:0];
    funct3 = f3[2:0];
    funct7 = f7[6:0];
    imm = im;
    req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: actual no ready required ready");
      req_valid = 1'b0;
      return;
    end
    if (legal) begin
      q.push_back('{a: m_next[AW-1:0], d: w});
      m_next++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("err", 32'(err), legal ? 32'd0 : 32'd1);
  endtask

  task automatic rand_req(int unsigned c);
    int unsigned a, b, d, f, g;
    logic [31:0] im;
    a = $urandom % 32;
    b = $urandom % 32;
    d = $urandom % 32;
    f = $urandom % 8;
    g = $urandom % 128;
    im = $urandom;
    do_req(c, a, b, d, f, g, im, ref_enc(c, a, b, d, f, g, im));
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !wr_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: actual %0d pending required 0",
               q.size());
      q.delete();
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_wr_valid"}, 32'(wr_valid), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    int n0;
    int legal;
    int unsigned c;

    #3;
    check_all_zero("reset");
    #10;
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 0);

    // basic encodes
    do_start(0);
    do_req(1, 1, 0, 0, 0, 0, 32'd5, 32'h00500093);
    do_req(0, 3, 1, 2, 0, 0, 32'd0, 32'h002081B3);
    do_req(3, 0, 1, 2, 2, 0, 32'd8, 32'h0020A423);
    do_req(7, 1, 0, 0, 0, 0, 32'd8, 32'h008000EF);
    wait_drain();
    check("basic_count", 32'(count), 4);

    // LUI held under backpressure
    set_ready(1'b0, 1'b0);
    n0 = n_xfer;
    do_req(5, 5, 0, 0, 0, 0, 32'h12345000, 32'h123452B7);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(wr_valid), 1);
      check("bp_data", wr_data, 32'h123452B7);
      check("bp_addr", 32'(wr_addr), 4);
      check("bp_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    set_ready(1'b0, 1'b1);
    wait_drain();
    check("bp_xfers", 32'(n_xfer - n0), 1);
    check("bp_count", 32'(count), 5);
    do_req(1, 2, 3, 0, 0, 0, 32'd7, ref_enc(1, 2, 3, 0, 0, 0, 7));
    wait_drain();

    // illegal class
    c0 = 32'(count);
    do_req(12, 1, 1, 1, 0, 0, 32'd1, 32'd0);
    check("ill_valid", 32'(wr_valid), 0);
    check("ill_count", 32'(count), c0);
    @(negedge clk);
    check("ill_err_once", 32'(err), 0);

    // fill to DEPTH across the wrap
    do_start(3);
    for (int i = 0; i < DP; i++) begin
      c = $urandom % 9;
      rand_req(c);
    end
    wait_drain();
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), DP);
    check("fill_ready", 32'(req_ready), 0);
    @(negedge clk);
    check("fill_ready2", 32'(req_ready), 0);

    // randomized batches
    for (int b = 0; b < 12; b++) begin
      do_start($urandom % 8);
      set_ready(1'b1, 1'b1);
      legal = 0;
      for (int k = 0; k < 10; k++) begin
        if (legal == DP) break;
        c = $urandom % 11;
        rand_req(c);
        if (c <= 8) legal++;
      end
      wait_drain();
      set_ready(1'b0, 1'b1);
      @(negedge clk);
      check("rnd_count", 32'(count), legal);
      check("rnd_xfers", 32'(n_xfer - xfer_at_start), legal);
      check("rnd_full", 32'(full), (legal == DP) ? 1 : 0);
    end

    // reset while a word is pending, then restart
    do_start(0);
    set_ready(1'b0, 1'b0);
    do_req(1, 4, 0, 0, 0, 0, 32'd9, ref_enc(1, 4, 0, 0, 0, 0, 9));
    check("pre_reset_valid", 32'(wr_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    q.delete();
    #10;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 32'(req_ready), 0);
    set_ready(1'b0, 1'b1);
    do_start(5);
    do_req(0, 7, 6, 5, 4, 32, 32'd0,
           ref_enc(0, 7, 6, 5, 4, 32, 0));
    wait_drain();
    check("restart_count", 32'(count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
